// File: rtl/prga.sv
// prga: RC4 pseudo-random generation stage, decrypts a length-prefixed ciphertext into pt memory.
// Optional PRGA_PRINTABLE_ABORT_EN: stop and flag bad on the first non-printable plaintext byte.
module prga #(
  parameter int CT_LEN_MAX = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] ct_addr,
  input  logic [7:0] ct_rddata,
  output logic [7:0] pt_addr,
  output logic [7:0] pt_wrdata,
  output logic       pt_wren,
  output logic       bad
);
  localparam logic [7:0] LMAX = 8'(CT_LEN_MAX);
  typedef enum logic [3:0] {
    IDLE, RD_LEN, WR_LEN, RD_SI, WAIT_SI, RD_SJ, WAIT_SJ, WR_SI, WR_SJ, RD_PAD, WAIT_PAD, WR_PT
  } state_t;
  state_t state;
  logic [7:0] i, j, k, len, si, sj;
  logic [7:0] l_in, pt_byte;
  logic last;
  assign l_in = (ct_rddata > LMAX) ? LMAX : ct_rddata;
  assign pt_byte = s_rddata ^ ct_rddata;
`ifdef PRGA_PRINTABLE_ABORT_EN
  logic bad_q, unprintable;
  assign unprintable = (pt_byte < 8'h20) || (pt_byte > 8'h7e);
  assign last = (k == len) || unprintable;
  assign bad = bad_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) bad_q <= 1'b0;
    else if (state == IDLE && en) bad_q <= 1'b0;
    else if (state == WR_PT && unprintable) bad_q <= 1'b1;
`else
  assign last = k == len;
  assign bad = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      i <= 8'd0;
      j <= 8'd0;
      k <= 8'd0;
      len <= 8'd0;
      si <= 8'd0;
      sj <= 8'd0;
    end else begin
      case (state)
        IDLE: if (en) state <= RD_LEN;
        RD_LEN: begin
          i <= 8'd0;
          j <= 8'd0;
          k <= 8'd1;
          state <= WR_LEN;
        end
        WR_LEN: begin
          len <= l_in;
          state <= (l_in == 8'd0) ? IDLE : RD_SI;
        end
        RD_SI: begin
          i <= i + 8'd1;
          state <= WAIT_SI;
        end
        WAIT_SI: state <= RD_SJ;
        RD_SJ: begin
          si <= s_rddata;
          j <= j + s_rddata;
          state <= WAIT_SJ;
        end
        WAIT_SJ: state <= WR_SI;
        WR_SI: begin
          sj <= s_rddata;
          state <= WR_SJ;
        end
        WR_SJ: state <= RD_PAD;
        RD_PAD: state <= WAIT_PAD;
        WAIT_PAD: state <= WR_PT;
        WR_PT: begin
          if (!last) k <= k + 8'd1;
          state <= last ? IDLE : RD_SI;
        end
        default: state <= IDLE;
      endcase
    end
  // The pad index uses the captured si/sj, so an i==j swap still yields the right pad.
  assign rdy = state == IDLE;
  assign s_addr = (state == RD_SI) ? i + 8'd1 :
                  (state == WAIT_SI || state == WR_SI) ? i :
                  (state == RD_SJ) ? j + s_rddata :
                  (state == WAIT_SJ || state == WR_SJ) ? j :
                  (state == RD_PAD || state == WAIT_PAD) ? si + sj : 8'd0;
  assign s_wrdata = (state == WR_SI) ? s_rddata : (state == WR_SJ) ? si : 8'd0;
  assign s_wren = (state == WR_SI) || (state == WR_SJ);
  assign ct_addr = (state == WR_SJ || state == RD_PAD || state == WAIT_PAD) ? k : 8'd0;
  assign pt_addr = (state == WR_PT) ? k : 8'd0;
  assign pt_wrdata = (state == WR_LEN) ? l_in : (state == WR_PT) ? pt_byte : 8'd0;
  assign pt_wren = (state == WR_LEN) || (state == WR_PT);
endmodule

// File: tb/tb_prga.sv
// tb_prga: checks two prga instances (default and CT_LEN_MAX=4) against constant vectors and an RC4 model.
module tb_prga;
  logic clk, rst, en, load;
  logic [1:0] rdy, s_wren, pt_wren, bad_o;
  logic [1:0][7:0] s_addr, s_rd, s_wd, ct_addr, ct_rd, pt_addr, pt_wd;
  logic [7:0] s_init [256];
  logic [7:0] ct_mem [256];
  logic [7:0] s_mem [2][256];
  logic [7:0] pt_mem [2][256];
  logic pt_wr [2][256];
  int swc [2], pwc [2];
  int ms [2][256];
  int exp_pt [2][256];
  bit exp_w [2][256];
  int exp_cyc [2], exp_bad [2], exp_swc [2], exp_pwc [2];
  int total, nbad;
`ifdef PRGA_PRINTABLE_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif
  typedef struct {
    logic [79:0] ct, pt;
    int n0, n1, cyc0, cyc1;
    logic [7:0] l1;
    logic bad;
  } vec_t;
  vec_t vecs [4];

  prga u0 (.clk(clk), .rst(rst), .en(en), .rdy(rdy[0]), .s_addr(s_addr[0]), .s_rddata(s_rd[0]),
    .s_wrdata(s_wd[0]), .s_wren(s_wren[0]), .ct_addr(ct_addr[0]), .ct_rddata(ct_rd[0]),
    .pt_addr(pt_addr[0]), .pt_wrdata(pt_wd[0]), .pt_wren(pt_wren[0]), .bad(bad_o[0]));
  prga #(.CT_LEN_MAX(4)) u1 (.clk(clk), .rst(rst), .en(en), .rdy(rdy[1]), .s_addr(s_addr[1]),
    .s_rddata(s_rd[1]), .s_wrdata(s_wd[1]), .s_wren(s_wren[1]), .ct_addr(ct_addr[1]),
    .ct_rddata(ct_rd[1]), .pt_addr(pt_addr[1]), .pt_wrdata(pt_wd[1]), .pt_wren(pt_wren[1]),
    .bad(bad_o[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      s_rd[d] <= s_mem[d][s_addr[d]];
      ct_rd[d] <= ct_mem[ct_addr[d]];
      if (load) begin
        swc[d] <= 0;
        pwc[d] <= 0;
        for (int x = 0; x < 256; x++) begin
          s_mem[d][x] <= s_init[x];
          pt_mem[d][x] <= 8'h00;
          pt_wr[d][x] <= 1'b0;
        end
      end else begin
        if (s_wren[d]) begin
          s_mem[d][s_addr[d]] <= s_wd[d];
          swc[d] <= swc[d] + 1;
        end
        if (pt_wren[d]) begin
          pt_mem[d][pt_addr[d]] <= pt_wd[d];
          pt_wr[d][pt_addr[d]] <= 1'b1;
          pwc[d] <= pwc[d] + 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got !== want) begin
      nbad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic set_ident();
    for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
  endtask

  task automatic set_perm();
    logic [7:0] t;
    int r;
    set_ident();
    for (int x = 255; x > 0; x--) begin
      r = $urandom_range(x, 0);
      t = s_init[x];
      s_init[x] = s_init[r];
      s_init[r] = t;
    end
  endtask

  task automatic load_ct(input logic [79:0] v);
    for (int x = 0; x < 256; x++) ct_mem[x] = 8'h00;
    for (int b = 0; b < 10; b++) ct_mem[b] = v[79-8*b -: 8];
  endtask

  task automatic do_load();
    @(negedge clk) load = 1'b1;
    @(negedge clk) load = 1'b0;
  endtask

  task automatic model_init();
    for (int d = 0; d < 2; d++) begin
      exp_swc[d] = 0;
      exp_pwc[d] = 0;
      for (int x = 0; x < 256; x++) begin
        ms[d][x] = int'(s_init[x]);
        exp_w[d][x] = 1'b0;
        exp_pt[d][x] = 0;
      end
    end
  endtask

  // Plain RC4 keystream loop over the model copy of S, clamped to lmax bytes.
  task automatic model_run(input int d, input int lmax);
    int i = 0, j = 0, l, t, p, n = 0;
    l = (int'(ct_mem[0]) > lmax) ? lmax : int'(ct_mem[0]);
    exp_pt[d][0] = l;
    exp_w[d][0] = 1'b1;
    exp_bad[d] = 0;
    for (int k = 1; k <= l; k++) begin
      i = (i + 1) % 256;
      j = (j + ms[d][i]) % 256;
      t = ms[d][i];
      ms[d][i] = ms[d][j];
      ms[d][j] = t;
      p = ms[d][(ms[d][i] + ms[d][j]) % 256] ^ int'(ct_mem[k]);
      exp_pt[d][k] = p;
      exp_w[d][k] = 1'b1;
      n = k;
      if (ABORT && (p < 32 || p > 126)) begin
        exp_bad[d] = 1;
        break;
      end
    end
    exp_cyc[d] = 2 + 9 * n;
    exp_swc[d] += 2 * n;
    exp_pwc[d] += n + 1;
  endtask

  task automatic check_model(input int d, input int c, input string tag);
    int mp = 0, mm = 0;
    for (int x = 0; x < 256; x++) begin
      if (pt_wr[d][x] !== exp_w[d][x] || (exp_w[d][x] && pt_mem[d][x] !== 8'(exp_pt[d][x]))) mp++;
      if (s_mem[d][x] !== 8'(ms[d][x])) mm++;
    end
    chk($sformatf("%s u%0d cycles", tag, d), c, exp_cyc[d]);
    chk($sformatf("%s u%0d bad", tag, d), int'(bad_o[d]), exp_bad[d]);
    chk($sformatf("%s u%0d pt_mismatches", tag, d), mp, 0);
    chk($sformatf("%s u%0d s_mismatches", tag, d), mm, 0);
    chk($sformatf("%s u%0d s_writes", tag, d), swc[d], exp_swc[d]);
    chk($sformatf("%s u%0d pt_writes", tag, d), pwc[d], exp_pwc[d]);
  endtask

  task automatic wait_done(output int c0, output int c1);
    c0 = -1;
    c1 = -1;
    for (int t = 1; t <= 3000 && (c0 < 0 || c1 < 0); t++) begin
      @(posedge clk);
      #1;
      if (rdy[0] && c0 < 0) c0 = t;
      if (rdy[1] && c1 < 0) c1 = t;
    end
  endtask

  task automatic go(output int c0, output int c1);
    @(negedge clk) en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    wait_done(c0, c1);
  endtask

  initial begin
    int c0, c1, m0, m1, idle;
    total = 0;
    nbad = 0;
    rst = 1'b1;
    en = 1'b0;
    load = 1'b0;
    vecs[0] = '{80'h03414243000000000000, 80'h03434744000000000000, 4, 4, 29, 29, 8'h03, 1'b0};
    vecs[1] = '{80'h00000000000000000000, 80'h00000000000000000000, 1, 1, 2, 2, 8'h00, 1'b0};
    vecs[2] = '{80'h094344464c4c565e6969, 80'h09414141414141414141, 10, 5, 83, 38, 8'h04, 1'b0};
`ifdef PRGA_PRINTABLE_ABORT_EN
    vecs[3] = '{80'h02024100000000000000, 80'h02000000000000000000, 2, 2, 11, 11, 8'h02, 1'b1};
`else
    vecs[3] = '{80'h02024100000000000000, 80'h02004400000000000000, 3, 3, 20, 20, 8'h02, 1'b0};
`endif
    set_ident();
    load_ct(80'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset rdy", int'(rdy), 3);
    chk("reset wren", int'({s_wren, pt_wren}), 0);
    chk("reset bad", int'(bad_o), 0);
    chk("reset addrs", int'(s_addr) + int'(ct_addr) + int'(pt_addr), 0);
    @(negedge clk) rst = 1'b0;

    for (int v = 0; v < 4; v++) begin
      set_ident();
      load_ct(vecs[v].ct);
      do_load();
      model_init();
      model_run(0, 255);
      model_run(1, 4);
      go(c0, c1);
      m0 = 0;
      m1 = 0;
      for (int b = 1; b < vecs[v].n0; b++) if (pt_mem[0][b] !== vecs[v].pt[79-8*b -: 8]) m0++;
      for (int b = 1; b < vecs[v].n1; b++) if (pt_mem[1][b] !== vecs[v].pt[79-8*b -: 8]) m1++;
      chk($sformatf("vec%0d u0 cycles", v), c0, vecs[v].cyc0);
      chk($sformatf("vec%0d u1 cycles", v), c1, vecs[v].cyc1);
      chk($sformatf("vec%0d bad", v), int'(bad_o[0]), int'(vecs[v].bad));
      chk($sformatf("vec%0d u0 pt0", v), int'(pt_mem[0][0]), int'(vecs[v].pt[79:72]));
      chk($sformatf("vec%0d u1 pt0", v), int'(pt_mem[1][0]), int'(vecs[v].l1));
      chk($sformatf("vec%0d u0 pt bytes", v), m0, 0);
      chk($sformatf("vec%0d u1 pt bytes", v), m1, 0);
      chk($sformatf("vec%0d u0 pt count", v), pwc[0], vecs[v].n0);
      chk($sformatf("vec%0d u1 pt count", v), pwc[1], vecs[v].n1);
      chk($sformatf("vec%0d u0 untouched", v), int'(pt_wr[0][vecs[v].n0]), 0);
      chk($sformatf("vec%0d u1 untouched", v), int'(pt_wr[1][vecs[v].n1]), 0);
      check_model(0, c0, $sformatf("vec%0d", v));
      check_model(1, c1, $sformatf("vec%0d", v));
    end
    set_ident();
    load_ct(vecs[0].ct);
    do_load();
    go(c0, c1);
    chk("ident s2", int'(s_mem[0][2]), 3);
    chk("ident s3", int'(s_mem[0][3]), 5);
    chk("ident s5", int'(s_mem[0][5]), 2);

    // Reset lands in WAIT_PAD of byte 2: edge 19 after the accept.
    set_ident();
    load_ct(vecs[0].ct);
    do_load();
    @(negedge clk) en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    repeat (18) @(posedge clk);
    #1;
    chk("waitpad ct_addr", int'(ct_addr[0]), 2);
    chk("waitpad s_addr", int'(s_addr[0]), 5);
    chk("waitpad rdy", int'(rdy), 0);
    rst = 1'b1;
    #1;
    chk("midrst rdy", int'(rdy), 3);
    chk("midrst wren", int'({s_wren, pt_wren}), 0);
    @(posedge clk);
    #1;
    chk("midrst hold rdy", int'(rdy), 3);
    @(negedge clk) rst = 1'b0;
    chk("midrst pt1 kept", int'(pt_mem[0][1]), 8'h43);
    chk("midrst pt2 unwritten", int'(pt_wr[0][2]), 0);
    set_ident();
    do_load();
    model_init();
    model_run(0, 255);
    model_run(1, 4);
    go(c0, c1);
    check_model(0, c0, "after_rst");
    check_model(1, c1, "after_rst");

    // en held high: second run starts on the edge after rdy rises, from the updated S.
    set_ident();
    do_load();
    model_init();
    model_run(0, 255);
    model_run(0, 255);
    model_run(1, 4);
    model_run(1, 4);
    @(negedge clk) en = 1'b1;
    @(posedge clk);
    #1;
    wait_done(c0, c1);
    chk("b2b first cycles", c0, 29);
    @(posedge clk);
    #1;
    chk("b2b restart rdy", int'(rdy), 0);
    wait_done(c0, c1);
    en = 1'b0;
    check_model(0, c0, "b2b");
    check_model(1, c1, "b2b");

    // en pulses while busy are ignored; no restart once idle with en low.
    set_ident();
    do_load();
    model_init();
    model_run(0, 255);
    model_run(1, 4);
    @(negedge clk) en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    c0 = -1;
    c1 = -1;
    idle = 0;
    for (int t = 1; t <= 40; t++) begin
      @(posedge clk);
      #1;
      if (rdy[0] && c0 < 0) c0 = t;
      if (rdy[1] && c1 < 0) c1 = t;
      if (&rdy) idle++;
      @(negedge clk) en = (t >= 2 && t <= 26 && t % 3 == 0);
    end
    en = 1'b0;
    chk("pulse idle cycles", idle, 12);
    check_model(0, c0, "pulse");
    check_model(1, c1, "pulse");

    for (int r = 0; r < 30; r++) begin
      set_perm();
      for (int x = 1; x < 256; x++) ct_mem[x] = 8'($urandom);
      ct_mem[0] = (r < 4) ? 8'($urandom_range(255, 200)) : 8'($urandom_range(12, 0));
      do_load();
      model_init();
      model_run(0, 255);
      model_run(1, 4);
      go(c0, c1);
      check_model(0, c0, $sformatf("rand%0d", r));
      check_model(1, c1, $sformatf("rand%0d", r));
    end
    $display("test done: total=%0d bad=%0d", total, nbad);
    $finish;
  end
endmodule
